// File: rtl/bsg_priority_encode_one_hot_out.sv
// Priority encoder with a one-hot output. It isolates the highest-priority set bit of i.
// lo_to_hi_p=1 favours bit 0, and lo_to_hi_p=0 favours bit width_p-1.
module bsg_priority_encode_one_hot_out #(
  parameter int width_p    = 4,
  parameter bit lo_to_hi_p = 1'b1
) (
  input  logic [width_p-1:0] i,
  output logic [width_p-1:0] o,
  output logic               v_o
);

  localparam logic [width_p-1:0] ONE = width_p'(1);

  logic [width_p-1:0] w_ord;
  logic [width_p-1:0] w_iso;

  // Map the winning end to bit 0, so the two's-complement trick always keeps the lowest set bit.
  always_comb begin
    w_ord = '0;
    for (int k = 0; k < width_p; k++) begin
      if (lo_to_hi_p) w_ord[k] = i[k];
      else            w_ord[k] = i[width_p-1-k];
    end
  end

  assign w_iso = w_ord & (~w_ord + ONE);

  always_comb begin
    o = '0;
    for (int k = 0; k < width_p; k++) begin
      if (lo_to_hi_p) o[k] = w_iso[k];
      else            o[k] = w_iso[width_p-1-k];
    end
  end

  assign v_o = |i;

endmodule

// File: rtl/bsg_priority_crossbar.sv
// Priority crossbar: each output lane takes the highest-priority requesting input through an AND-OR select.
// Defining BSG_PRIORITY_CROSSBAR_OUT_REG_EN adds a synchronously reset output register with one cycle of latency.
module bsg_priority_crossbar #(
  parameter int width_p    = 64,
  parameter int i_els_p    = 4,
  parameter int o_els_p    = 1,
  parameter bit lo_to_hi_p = 1'b1
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [i_els_p-1:0][width_p-1:0]   i,
  input  logic [o_els_p-1:0][i_els_p-1:0]   req_i,
  output logic [o_els_p-1:0][i_els_p-1:0]   sel_one_hot_o,
  output logic [o_els_p-1:0]                v_o,
  output logic [o_els_p-1:0][width_p-1:0]   o
);

  logic [o_els_p-1:0][i_els_p-1:0] w_sel;
  logic [o_els_p-1:0]              w_v;
  logic [o_els_p-1:0][width_p-1:0] w_data;

  for (genvar j = 0; j < o_els_p; j++) begin : g_lane
    logic [width_p-1:0] w_and_or;

    bsg_priority_encode_one_hot_out #(
      .width_p    (i_els_p),
      .lo_to_hi_p (lo_to_hi_p)
    ) u_enc (
      .i   (req_i[j]),
      .o   (w_sel[j]),
      .v_o (w_v[j])
    );

    // The grant is one-hot or zero, so ORing the masked lanes selects at most one input.
    always_comb begin
      w_and_or = '0;
      for (int k = 0; k < i_els_p; k++) begin
        w_and_or = w_and_or | (i[k] & {width_p{w_sel[j][k]}});
      end
    end

    assign w_data[j] = w_and_or;
  end

`ifdef BSG_PRIORITY_CROSSBAR_OUT_REG_EN
  logic [o_els_p-1:0][i_els_p-1:0] r_sel;
  logic [o_els_p-1:0]              r_v;
  logic [o_els_p-1:0][width_p-1:0] r_data;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_sel  <= '0;
      r_v    <= '0;
      r_data <= '0;
    end else begin
      r_sel  <= w_sel;
      r_v    <= w_v;
      r_data <= w_data;
    end
  end

  assign sel_one_hot_o = r_sel;
  assign v_o           = r_v;
  assign o             = r_data;
`else
  logic w_unused;
  assign w_unused = clk_i | reset_i;

  assign sel_one_hot_o = w_sel;
  assign v_o           = w_v;
  assign o             = w_data;
`endif

endmodule

// File: tb/tb_bsg_priority_crossbar.sv
// Scoreboard bench for bsg_priority_crossbar, covering both priority orders, multiple output lanes and a single-input configuration.
// It follows BSG_PRIORITY_CROSSBAR_OUT_REG_EN to pick the expected latency.
module tb_bsg_priority_crossbar;

`ifdef BSG_PRIORITY_CROSSBAR_OUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [3:0][63:0]      in4;
  logic [0:0][3:0]       req_ab;
  logic [3:0][63:0]      in_c;
  logic [1:0][3:0]       req_c;
  logic [0:0][63:0]      in_d;
  logic [1:0][0:0]       req_d;

  logic                  nxt_rst;
  logic [3:0][63:0]      nxt_in4;
  logic [3:0]            nxt_req_ab;
  logic [3:0][63:0]      nxt_in_c;
  logic [1:0][3:0]       nxt_req_c;
  logic [63:0]           nxt_in_d;
  logic [1:0]            nxt_req_d;

  logic [0:0][3:0]       sel_a, sel_b;
  logic [0:0]            v_a, v_b;
  logic [0:0][63:0]      o_a, o_b;
  logic [1:0][3:0]       sel_c;
  logic [1:0]            v_c;
  logic [1:0][63:0]      o_c;
  logic [1:0][0:0]       sel_d;
  logic [1:0]            v_d;
  logic [1:0][63:0]      o_d;

  bsg_priority_crossbar #(.width_p(64), .i_els_p(4), .o_els_p(1), .lo_to_hi_p(1'b1)) dut_a (
    .clk_i(clk), .reset_i(rst), .i(in4), .req_i(req_ab),
    .sel_one_hot_o(sel_a), .v_o(v_a), .o(o_a));

  bsg_priority_crossbar #(.width_p(64), .i_els_p(4), .o_els_p(1), .lo_to_hi_p(1'b0)) dut_b (
    .clk_i(clk), .reset_i(rst), .i(in4), .req_i(req_ab),
    .sel_one_hot_o(sel_b), .v_o(v_b), .o(o_b));

  bsg_priority_crossbar #(.width_p(64), .i_els_p(4), .o_els_p(2), .lo_to_hi_p(1'b1)) dut_c (
    .clk_i(clk), .reset_i(rst), .i(in_c), .req_i(req_c),
    .sel_one_hot_o(sel_c), .v_o(v_c), .o(o_c));

  bsg_priority_crossbar #(.width_p(64), .i_els_p(1), .o_els_p(2), .lo_to_hi_p(1'b1)) dut_d (
    .clk_i(clk), .reset_i(rst), .i(in_d), .req_i(req_d),
    .sel_one_hot_o(sel_d), .v_o(v_d), .o(o_d));

  typedef struct {
    logic [63:0]  o_a, o_b;
    logic [3:0]   s_a, s_b;
    logic         v_a, v_b;
    logic [127:0] o_c;
    logic [7:0]   s_c;
    logic [1:0]   v_c;
    logic [127:0] o_d;
    logic [1:0]   s_d;
    logic [1:0]   v_d;
    string        tag;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  function automatic logic [3:0] pick4(input logic [3:0] r, input bit l2h);
    logic [3:0] g;
    int k;
    g = '0;
    for (int n = 0; n < 4; n++) begin
      k = l2h ? n : 3 - n;
      if (r[k] && g == 4'b0000) g[k] = 1'b1;
    end
    return g;
  endfunction

  function automatic logic [63:0] data4(input logic [3:0] sel, input logic [3:0][63:0] d);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) if (sel[k]) r = d[k];
    return r;
  endfunction

  // Apply the staged inputs just after a rising edge, then queue what the DUTs should show.
  task automatic step(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = nxt_rst;
    in4       = nxt_in4;
    req_ab[0] = nxt_req_ab;
    in_c      = nxt_in_c;
    req_c     = nxt_req_c;
    in_d[0]   = nxt_in_d;
    req_d[0][0] = nxt_req_d[0];
    req_d[1][0] = nxt_req_d[1];
    e.tag = tag;
    e.s_a = pick4(nxt_req_ab, 1'b1);
    e.s_b = pick4(nxt_req_ab, 1'b0);
    e.v_a = nxt_req_ab != 4'b0000;
    e.v_b = e.v_a;
    e.o_a = data4(e.s_a, nxt_in4);
    e.o_b = data4(e.s_b, nxt_in4);
    e.s_c = {pick4(nxt_req_c[1], 1'b1), pick4(nxt_req_c[0], 1'b1)};
    e.v_c = {nxt_req_c[1] != 4'b0000, nxt_req_c[0] != 4'b0000};
    e.o_c = {data4(e.s_c[7:4], nxt_in_c), data4(e.s_c[3:0], nxt_in_c)};
    e.s_d = nxt_req_d;
    e.v_d = nxt_req_d;
    e.o_d = {nxt_req_d[1] ? nxt_in_d : 64'h0, nxt_req_d[0] ? nxt_in_d : 64'h0};
    if (LAT == 1 && nxt_rst) begin
      e.o_a = '0; e.o_b = '0; e.s_a = '0; e.s_b = '0; e.v_a = 1'b0; e.v_b = 1'b0;
      e.o_c = '0; e.s_c = '0; e.v_c = '0; e.o_d = '0; e.s_d = '0; e.v_d = '0;
    end
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > LAT) begin
      e = q.pop_front();
      chk({e.tag, "/o_a"},   128'(o_a),   128'(e.o_a));
      chk({e.tag, "/sel_a"}, 128'(sel_a), 128'(e.s_a));
      chk({e.tag, "/v_a"},   128'(v_a),   128'(e.v_a));
      chk({e.tag, "/o_b"},   128'(o_b),   128'(e.o_b));
      chk({e.tag, "/sel_b"}, 128'(sel_b), 128'(e.s_b));
      chk({e.tag, "/v_b"},   128'(v_b),   128'(e.v_b));
      chk({e.tag, "/o_c"},   128'(o_c),   e.o_c);
      chk({e.tag, "/sel_c"}, 128'(sel_c), 128'(e.s_c));
      chk({e.tag, "/v_c"},   128'(v_c),   128'(e.v_c));
      chk({e.tag, "/o_d"},   128'(o_d),   e.o_d);
      chk({e.tag, "/sel_d"}, 128'(sel_d), 128'(e.s_d));
      chk({e.tag, "/v_d"},   128'(v_d),   128'(e.v_d));
      chk({e.tag, "/onehot_a"},  128'($onehot0(sel_a)),    128'(1));
      chk({e.tag, "/onehot_b"},  128'($onehot0(sel_b)),    128'(1));
      chk({e.tag, "/onehot_c0"}, 128'($onehot0(sel_c[0])), 128'(1));
      chk({e.tag, "/onehot_c1"}, 128'($onehot0(sel_c[1])), 128'(1));
    end
  end

  task automatic zero_next();
    nxt_in4 = '0; nxt_req_ab = '0; nxt_in_c = '0; nxt_req_c = '0;
    nxt_in_d = '0; nxt_req_d = '0;
  endtask

  initial begin
    rst = 1'b1; in4 = '0; req_ab = '0; in_c = '0; req_c = '0; in_d = '0; req_d = '0;
    nxt_rst = 1'b1;
    zero_next();
    step("reset0");
    step("reset1");

    nxt_rst    = 1'b0;
    nxt_in4    = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                  64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    nxt_req_ab = 4'b1010;
    nxt_in_c   = {64'h3333, 64'h2222, 64'h1111, 64'hDEAD_BEEF};
    nxt_req_c  = {4'b0001, 4'b0001};
    nxt_in_d   = 64'h0123_4567_89AB_CDEF;
    nxt_req_d  = 2'b01;
    step("req1010");

    nxt_req_ab = 4'b0000;
    nxt_req_c  = {4'b0000, 4'b1100};
    nxt_req_d  = 2'b10;
    step("req0000");

    nxt_in4[2] = 64'h1234;
    nxt_req_ab = 4'b0100;
    nxt_req_c  = {4'b1000, 4'b0110};
    nxt_req_d  = 2'b11;
    step("req0100");

    nxt_rst    = 1'b1;
    nxt_req_ab = 4'b1111;
    nxt_req_c  = {4'b1111, 4'b1111};
    step("rst_mid");

    nxt_rst    = 1'b0;
    nxt_req_ab = 4'b1010;
    step("post_rst");

    for (int n = 0; n < 1000; n++) begin
      for (int k = 0; k < 4; k++) begin
        nxt_in4[k]  = {$urandom, $urandom};
        nxt_in_c[k] = {$urandom, $urandom};
      end
      nxt_in_d   = {$urandom, $urandom};
      nxt_req_ab = 4'($urandom_range(0, 15));
      nxt_req_c  = 8'($urandom);
      nxt_req_d  = 2'($urandom_range(0, 3));
      step("rand");
    end

    zero_next();
    step("idle0");
    step("idle1");
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
